fir_stream_arbiter: RTL and testbench



---
 rtl/fir_stream_arbiter.sv | 134 +++++++++++++
 tb/tb_fir_stream_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding one FIR datapath from two AXI-Stream sources.
// Define FIR_ARB_FLUSH_EN to append FLUSH_LEN zero beats after every packet.
module fir_stream_arbiter #(
  parameter int DATA_W      = 16,
  parameter int MAX_PKT_LEN = 256,
  parameter int FLUSH_LEN   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic              s0_axis_tvalid,
  input  logic              s0_axis_tlast,
  output logic              s0_axis_tready,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic              s1_axis_tvalid,
  input  logic              s1_axis_tlast,
  output logic              s1_axis_tready,
  output logic [DATA_W-1:0] m_axis_fir_tdata,
  output logic              m_axis_fir_tvalid,
  output logic              m_axis_fir_tlast,
  input  logic              m_axis_fir_tready,
  output logic              m_axis_fir_tdest,
  output logic              m_flush,
  output logic              err_overlen,
  input  logic              err_clr
);
  localparam logic [1:0]  IDLE      = 2'd0;
  localparam logic [1:0]  GRANT0    = 2'd1;
  localparam logic [1:0]  GRANT1    = 2'd2;
  localparam logic [15:0] LAST_BEAT = 16'(MAX_PKT_LEN - 1);

`ifdef FIR_ARB_FLUSH_EN
  localparam logic [1:0] FLUSH = 2'd3;
  localparam int         FW    = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  logic [FW-1:0] flush_cnt;
`else
  logic unused_flush_len;
  assign unused_flush_len = |FLUSH_LEN;
`endif

  logic [1:0]        state;
  logic              last_grant;
  logic [15:0]       beat_cnt;
  logic              in_grant, sel, sel_valid, sel_last, at_max, accept, trunc;
  logic [DATA_W-1:0] sel_data;

  assign in_grant  = (state == GRANT0) || (state == GRANT1);
  assign sel       = (state == GRANT1);
  assign sel_data  = sel ? s1_axis_tdata  : s0_axis_tdata;
  assign sel_valid = sel ? s1_axis_tvalid : s0_axis_tvalid;
  assign sel_last  = sel ? s1_axis_tlast  : s0_axis_tlast;
  assign at_max    = (beat_cnt == LAST_BEAT);
  assign accept    = m_axis_fir_tvalid && m_axis_fir_tready;
  // Cutting a packet at the length limit is only an error if the source did not end it there itself.
  assign trunc     = in_grant && accept && at_max && !sel_last;

  always_comb begin
    m_axis_fir_tdata  = '0;
    m_axis_fir_tvalid = 1'b0;
    m_axis_fir_tlast  = 1'b0;
    m_axis_fir_tdest  = 1'b0;
    m_flush           = 1'b0;
    s0_axis_tready    = (state == GRANT0) && m_axis_fir_tready;
    s1_axis_tready    = (state == GRANT1) && m_axis_fir_tready;
    if (in_grant) begin
      m_axis_fir_tdata  = sel_data;
      m_axis_fir_tvalid = sel_valid;
      m_axis_fir_tlast  = sel_last || at_max;
      m_axis_fir_tdest  = sel;
    end
`ifdef FIR_ARB_FLUSH_EN
    else if (state == FLUSH) begin
      m_axis_fir_tvalid = 1'b1;
      m_axis_fir_tlast  = (flush_cnt == FW'(FLUSH_LEN - 1));
      m_axis_fir_tdest  = last_grant;
      m_flush           = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      beat_cnt    <= '0;
      err_overlen <= 1'b0;
`ifdef FIR_ARB_FLUSH_EN
      flush_cnt   <= '0;
`endif
    end else begin
      if (trunc)        err_overlen <= 1'b1;
      else if (err_clr) err_overlen <= 1'b0;
      case (state)
        IDLE: begin
          // On a tie the source that did not go last wins.
          if (s0_axis_tvalid && (!s1_axis_tvalid || last_grant)) begin
            state      <= GRANT0;
            last_grant <= 1'b0;
            beat_cnt   <= '0;
          end else if (s1_axis_tvalid) begin
            state      <= GRANT1;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
          end
        end
        GRANT0, GRANT1: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 16'd1;
            if (m_axis_fir_tlast) begin
`ifdef FIR_ARB_FLUSH_EN
              state <= FLUSH;
`else
              state <= IDLE;
`endif
            end
          end
        end
`ifdef FIR_ARB_FLUSH_EN
        FLUSH: begin
          if (accept) begin
            if (m_axis_fir_tlast) begin
              flush_cnt <= '0;
              state     <= IDLE;
            end else begin
              flush_cnt <= flush_cnt + 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_stream_arbiter.sv
// Randomized + directed bench for fir_stream_arbiter against a packet-level reference model.
module tb_fir_stream_arbiter;
  localparam int DW   = 16;
  localparam int MAXL = 8;
  localparam int FLEN = 15;
`ifdef FIR_ARB_FLUSH_EN
  localparam int FL = 1;
`else
  localparam int FL = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] s_d [2];
  logic          s_v [2];
  logic          s_l [2];
  logic          s0_axis_tready, s1_axis_tready;
  logic [DW-1:0] m_axis_fir_tdata;
  logic          m_axis_fir_tvalid, m_axis_fir_tlast, m_axis_fir_tdest, m_flush;
  logic          m_rdy = 1'b0;
  logic          err_overlen;
  logic          err_clr = 1'b0;

  always #5 clk = ~clk;

  fir_stream_arbiter #(.DATA_W(DW), .MAX_PKT_LEN(MAXL), .FLUSH_LEN(FLEN)) dut (
    .clk(clk), .reset(reset),
    .s0_axis_tdata(s_d[0]), .s0_axis_tvalid(s_v[0]), .s0_axis_tlast(s_l[0]), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s_d[1]), .s1_axis_tvalid(s_v[1]), .s1_axis_tlast(s_l[1]), .s1_axis_tready(s1_axis_tready),
    .m_axis_fir_tdata(m_axis_fir_tdata), .m_axis_fir_tvalid(m_axis_fir_tvalid),
    .m_axis_fir_tlast(m_axis_fir_tlast), .m_axis_fir_tready(m_rdy),
    .m_axis_fir_tdest(m_axis_fir_tdest), .m_flush(m_flush),
    .err_overlen(err_overlen), .err_clr(err_clr)
  );

  typedef struct { logic [15:0] d; logic l; } beat_t;
  typedef struct { logic [15:0] d; logic l; logic dest; logic fl; } obeat_t;

  beat_t  q0[$], q1[$];
  obeat_t olog[$];
  obeat_t nfq[$];
  bit     rdy_pat[$];
  int     n_chk = 0, n_fail = 0;
  int     in_cnt[2], out_cnt[2];
  int     vld_pct = 100, rdy_pct = 100, clr_pct = 0;
  bit     clr_pend = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: arbitration state at packet granularity, checked every cycle at negedge.
  int          mode = 0;  // 0 between packets, 1 packet in progress, 2 flush burst
  bit          own = 0, lastg = 1, err = 0, on = 0, acc;
  int          nb = 0, nf = 0;
  logic [15:0] e_d;
  bit          e_v, e_l, e_dest, e_fl, e_r0, e_r1;

  always @(negedge clk) begin
    e_d = '0; e_v = 0; e_l = 0; e_dest = 0; e_fl = 0; e_r0 = 0; e_r1 = 0;
    if (mode == 1) begin
      e_v = s_v[own]; e_d = s_d[own]; e_dest = own;
      e_l = s_l[own] || (nb == MAXL - 1);
      if (own) e_r1 = m_rdy; else e_r0 = m_rdy;
    end else if (mode == 2) begin
      e_v = 1; e_fl = 1; e_dest = lastg; e_l = (nf == FLEN - 1);
    end
    if (on) begin
      chk("m_tvalid", m_axis_fir_tvalid, e_v);
      chk("m_tdata", m_axis_fir_tdata, e_d);
      chk("m_tlast", m_axis_fir_tlast, e_l);
      chk("m_tdest", m_axis_fir_tdest, e_dest);
      chk("m_flush", m_flush, e_fl);
      chk("s0_tready", s0_axis_tready, e_r0);
      chk("s1_tready", s1_axis_tready, e_r1);
      chk("err_overlen", err_overlen, err);
    end
    if (!reset && m_axis_fir_tvalid && m_rdy) begin
      olog.push_back('{m_axis_fir_tdata, m_axis_fir_tlast, m_axis_fir_tdest, m_flush});
      if (!m_flush) out_cnt[m_axis_fir_tdest]++;
    end
    if (reset) begin
      mode = 0; lastg = 1; err = 0; nb = 0; nf = 0; on = 1;
    end else begin
      acc = e_v && m_rdy;
      if (mode == 1 && acc && e_l && !s_l[own]) err = 1;
      else if (err_clr) err = 0;
      case (mode)
        0: if (s_v[0] && (!s_v[1] || lastg)) begin mode = 1; own = 0; lastg = 0; nb = 0; end
           else if (s_v[1]) begin mode = 1; own = 1; lastg = 1; nb = 0; end
        1: if (acc) begin nb++; if (e_l) begin mode = (FL != 0) ? 2 : 0; nf = 0; end end
        2: if (acc) begin if (e_l) mode = 0; else nf++; end
        default: mode = 0;
      endcase
    end
  end

  // One clock of stimulus: retire handshaken beats, then drive the next cycle's inputs.
  task automatic step();
    bit hs0, hs1;
    @(negedge clk);
    hs0 = s_v[0] && s0_axis_tready && !reset;
    hs1 = s_v[1] && s1_axis_tready && !reset;
    @(posedge clk); #1;
    if (hs0) begin void'(q0.pop_front()); in_cnt[0]++; end
    if (hs1) begin void'(q1.pop_front()); in_cnt[1]++; end
    if (reset) begin q0.delete(); q1.delete(); end
    s_v[0] = (q0.size() > 0) && ((s_v[0] && !hs0) || ($urandom_range(99) < vld_pct));
    s_v[1] = (q1.size() > 0) && ((s_v[1] && !hs1) || ($urandom_range(99) < vld_pct));
    s_d[0] = (q0.size() > 0) ? q0[0].d : '0;
    s_l[0] = (q0.size() > 0) ? q0[0].l : 1'b0;
    s_d[1] = (q1.size() > 0) ? q1[0].d : '0;
    s_l[1] = (q1.size() > 0) ? q1[0].l : 1'b0;
    if (rdy_pat.size() > 0) m_rdy = rdy_pat.pop_front();
    else                    m_rdy = ($urandom_range(99) < rdy_pct);
    err_clr  = clr_pend || ($urandom_range(99) < clr_pct);
    clr_pend = 0;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic push(int s, int n, int base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = 16'(base + i);
      b.l = (i == n - 1);
      if (s == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  task automatic get_nf();
    nfq.delete();
    foreach (olog[i]) if (!olog[i].fl) nfq.push_back(olog[i]);
  endtask

  initial begin
    int          t1[4] = '{100, -200, 300, -400};
    int          lens[$];
    int          dests[$];
    int          cnt;
    logic [15:0] ev;
    s_d = '{'0, '0}; s_v = '{0, 0}; s_l = '{0, 0};
    in_cnt = '{0, 0}; out_cnt = '{0, 0};

    reset = 1; run(3); reset = 0;
    chk("rst_tvalid", m_axis_fir_tvalid, 0);
    chk("rst_s0_tready", s0_axis_tready, 0);
    chk("rst_err", err_overlen, 0);

    // Single s0 packet
    olog.delete();
    for (int i = 0; i < 4; i++) push(0, 1, 0);
    foreach (t1[i]) begin q0[i].d = 16'(t1[i]); q0[i].l = (i == 3); end
    run(30);
    chk("t1_len", olog.size(), 4 + FLEN * FL);
    if (olog.size() >= 4) for (int i = 0; i < 4; i++) begin
      ev = 16'(t1[i]);
      chk("t1_data", olog[i].d, ev);
      chk("t1_last", olog[i].l, (i == 3));
      chk("t1_dest", olog[i].dest, 0);
    end
    for (int i = 4; i < olog.size(); i++) begin
      chk("t1_flush_fl", olog[i].fl, 1);
      chk("t1_flush_data", olog[i].d, 0);
      chk("t1_flush_last", olog[i].l, (i == 4 + FLEN - 1));
    end

    // Overlong s1 packet: 10 beats become 8 + 2
    olog.delete();
    push(1, 10, 500);
    run(60);
    get_nf();
    lens.delete(); cnt = 0;
    foreach (nfq[i]) begin
      cnt++;
      if (nfq[i].l) begin lens.push_back(cnt); cnt = 0; end
      ev = 16'(500 + i);
      chk("tr_data", nfq[i].d, ev);
      chk("tr_dest", nfq[i].dest, 1);
    end
    chk("tr_npkt", lens.size(), 2);
    if (lens.size() >= 2) begin
      chk("tr_len0", lens[0], 8);
      chk("tr_len1", lens[1], 2);
    end
    chk("tr_err_set", err_overlen, 1);
    clr_pend = 1; run(2);
    chk("tr_err_clr", err_overlen, 0);

    // Both sources backlogged; last grant was s1, so s0 goes first
    olog.delete();
    push(0, 3, 1000); push(0, 3, 1010); push(1, 3, 2000); push(1, 3, 2010);
    run(120);
    get_nf();
    dests.delete();
    foreach (nfq[i]) if (nfq[i].l) dests.push_back(nfq[i].dest);
    chk("rr_nbeats", nfq.size(), 12);
    chk("rr_npkt", dests.size(), 4);
    if (dests.size() >= 4) for (int i = 0; i < 4; i++) chk("rr_order", dests[i], i % 2);

    // Downstream stall 1,0,0,1 mid-packet
    olog.delete();
    push(0, 4, 600);
    rdy_pat = '{1, 1, 0, 0, 1, 1, 1};
    run(40);
    get_nf();
    chk("st_nbeats", nfq.size(), 4);
    foreach (nfq[i]) begin
      ev = 16'(600 + i);
      chk("st_data", nfq[i].d, ev);
      chk("st_last", nfq[i].l, (i == 3));
    end

    // Reset on beat 2 of a 5-beat s1 packet
    olog.delete();
    push(1, 5, 700);
    cnt = 0;
    while (olog.size() < 1 && cnt < 20) begin step(); cnt++; end
    chk("rs_reach_beat2", cnt < 20, 1);
    reset = 1; step(); reset = 0;
    chk("rs_tvalid", m_axis_fir_tvalid, 0);
    chk("rs_tlast", m_axis_fir_tlast, 0);
    chk("rs_s1_tready", s1_axis_tready, 0);
    chk("rs_tdest", m_axis_fir_tdest, 0);
    olog.delete();
    push(0, 3, 800); push(1, 3, 900);
    run(40);
    chk("rs_first_n", olog.size() > 0, 1);
    if (olog.size() > 0) begin
      chk("rs_first_dest", olog[0].dest, 0);
      chk("rs_first_data", olog[0].d, 800);
    end

    // Randomized traffic, random backpressure and error clears
    vld_pct = $urandom_range(50, 100); rdy_pct = 70; clr_pct = 5;
    for (int k = 0; k < 40; k++) push($urandom_range(1), $urandom_range(1, 12), $urandom_range(65535));
    cnt = 0;
    while ((q0.size() > 0 || q1.size() > 0) && cnt < 20000) begin step(); cnt++; end
    chk("rnd_drain_bound", cnt < 20000, 1);
    rdy_pct = 100; clr_pct = 0;
    run(40);
    chk("cnt_src0", out_cnt[0], in_cnt[0]);
    chk("cnt_src1", out_cnt[1], in_cnt[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
